axi_lite_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank. It is the next-generation control/status front end for the AES core, replacing the fixed 4-register slave interface. Register count and address width are configurable, with byte-strobe writes, per-register write pulses and SLVERR on out-of-range accesses. The core-side flat register bus feeds the AES datapath (key, plaintext, control).

---
 rtl/axi_lite_regbank.sv | 198 +++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: byte-strobe writes, per-register commit
// pulses, SLVERR on out-of-range accesses.
// Ports: ACLK/ARESET (sync, active-high), AXI4-Lite AW/W/B/AR/R,
// regs_out (flat registers), wr_pulse (commit strobes), status_in.
// Option: define REGBANK_STATUS_EN to make register NUM_REGS-1 a
// read-only view of status_in.
module axi_lite_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [DATA_WIDTH-1:0]          status_in
);
  localparam int IDXW = ADDR_WIDTH - 2;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP
  } wstate_t;

  wstate_t               wstate;
  logic [IDXW-1:0]       aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NBYTES-1:0]     w_strb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  wr_commit;
  logic [IDXW-1:0]       ar_idx;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_word;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  // Commit on the edge that raises BVALID.
  assign wr_commit = (wstate == W_RESP) && !S_AXI_BVALID;

  function automatic logic writable(input logic [IDXW-1:0] idx);
`ifdef REGBANK_STATUS_EN
    return 32'(idx) < NUM_REGS - 1;
`else
    return 32'(idx) < NUM_REGS;
`endif
  endfunction

  always_comb begin
    rd_word = '0;
    rd_ok = 32'(ar_idx) < NUM_REGS;
    for (int k = 0; k < NUM_REGS; k++)
      if (ar_idx == IDXW'(k))
        rd_word = regs[k];
`ifdef REGBANK_STATUS_EN
    if (ar_idx == IDXW'(NUM_REGS - 1))
      rd_word = status_in;
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= OKAY;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      wr_pulse <= '0;
      for (int k = 0; k < NUM_REGS; k++)
        regs[k] <= RESET_VAL;
    end else begin
      wr_pulse <= '0;
      if (aw_hs)
        aw_idx <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      unique case (wstate)
        W_IDLE: begin
          S_AXI_AWREADY <= !aw_hs;
          S_AXI_WREADY <= !w_hs;
          if (aw_hs && w_hs)
            wstate <= W_RESP;
          else if (aw_hs)
            wstate <= W_HAVE_AW;
          else if (w_hs)
            wstate <= W_HAVE_W;
        end
        W_HAVE_AW: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY <= !w_hs;
          if (w_hs)
            wstate <= W_RESP;
        end
        W_HAVE_W: begin
          S_AXI_WREADY <= 1'b0;
          S_AXI_AWREADY <= !aw_hs;
          if (aw_hs)
            wstate <= W_RESP;
        end
        W_RESP: begin
          if (!S_AXI_BVALID) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP <= writable(aw_idx) ? OKAY : SLVERR;
          end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY <= 1'b1;
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_commit && writable(aw_idx) &&
            aw_idx == IDXW'(k)) begin
          wr_pulse[k] <= 1'b1;
          for (int b = 0; b < NBYTES; b++)
            if (w_strb[b])
              regs[k][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= OKAY;
    end else if (ar_hs) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA <= rd_ok ? rd_word : '0;
      S_AXI_RRESP <= rd_ok ? OKAY : SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID <= 1'b0;
    end else begin
      S_AXI_ARREADY <= !S_AXI_RVALID;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
`ifdef REGBANK_STATUS_EN
    if (k == NUM_REGS - 1) begin : g_stat
      assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = status_in;
    end else begin : g_reg
      assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end
`else
    assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
`endif
  end

  logic unused_bits;
`ifdef REGBANK_STATUS_EN
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         status_in};
`endif

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Testbench for axi_lite_regbank: directed AXI4-Lite transactions
// checked against a transaction-level model every cycle.
module tb_axi_lite_regbank;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam int FW = NR * DW;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic [AW-1:0] araddr = '0;
  logic [2:0]    awprot = '0;
  logic [2:0]    arprot = '0;
  logic          awvalid = 1'b0;
  logic          wvalid = 1'b0;
  logic          bready = 1'b0;
  logic          arvalid = 1'b0;
  logic          rready = 1'b0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic [31:0]   status_in = 32'hA5A5A5A5;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [FW-1:0] regs_out;
  logic [NR-1:0] wr_pulse;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_regbank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VAL(32'h0)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .status_in(status_in)
  );

  task automatic chk(input string nm, input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0]   m_regs [NR];
  logic [AW-1:0] aw_q [$];
  logic [31:0]   wd_q [$];
  logic [3:0]    ws_q [$];
  bit            m_seen, m_live, m_due, m_bvalid, m_rvalid;
  logic [1:0]    m_bresp, m_rresp;
  logic [31:0]   m_rdata;
  logic [NR-1:0] m_pulse;
  logic [AW-1:0] due_a;
  logic [31:0]   due_d;
  logic [3:0]    due_s;

  function automatic bit is_status(input int ix);
`ifdef REGBANK_STATUS_EN
    return ix == NR - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit e_awready();
    return m_live && aw_q.size() == 0 && !m_due && !m_bvalid;
  endfunction
  function automatic bit e_wready();
    return m_live && wd_q.size() == 0 && !m_due && !m_bvalid;
  endfunction
  function automatic bit e_arready();
    return m_live && !m_rvalid;
  endfunction

  function automatic logic [FW-1:0] m_flat();
    logic [FW-1:0] f;
    for (int k = 0; k < NR; k++)
      f[k*DW +: DW] = is_status(k) ? status_in : m_regs[k];
    return f;
  endfunction

  always @(posedge ACLK) begin
    bit awr, wr, arr;
    int ix;
    m_seen = 1'b1;
    m_pulse = '0;
    if (ARESET) begin
      m_live = 0; m_due = 0; m_bvalid = 0; m_rvalid = 0;
      m_bresp = 0; m_rresp = 0; m_rdata = 0;
      aw_q.delete(); wd_q.delete(); ws_q.delete();
      for (int k = 0; k < NR; k++) m_regs[k] = 32'h0;
    end else begin
      awr = e_awready(); wr = e_wready(); arr = e_arready();
      // reads see register contents from before this edge's commit
      if (m_rvalid && rready) m_rvalid = 0;
      else if (arvalid && arr) begin
        ix = int'(araddr[AW-1:2]);
        m_rvalid = 1;
        if (ix < NR) begin
          m_rdata = is_status(ix) ? status_in : m_regs[ix];
          m_rresp = 2'b00;
        end else begin
          m_rdata = 0;
          m_rresp = 2'b10;
        end
      end
      if (m_bvalid && bready) m_bvalid = 0;
      if (m_due) begin
        ix = int'(due_a[AW-1:2]);
        if (ix < NR && !is_status(ix)) begin
          for (int b = 0; b < 4; b++)
            if (due_s[b]) m_regs[ix][b*8 +: 8] = due_d[b*8 +: 8];
          m_pulse[ix] = 1'b1;
          m_bresp = 2'b00;
        end else m_bresp = 2'b10;
        m_bvalid = 1; m_due = 0;
      end
      if (awvalid && awr) aw_q.push_back(awaddr);
      if (wvalid && wr) begin
        wd_q.push_back(wdata); ws_q.push_back(wstrb);
      end
      if (aw_q.size() > 0 && wd_q.size() > 0) begin
        due_a = aw_q.pop_front();
        due_d = wd_q.pop_front();
        due_s = ws_q.pop_front();
        m_due = 1;
      end
      m_live = 1;
    end
  end

  always @(negedge ACLK) begin
    if (m_seen) begin
      chk("regs_out", regs_out, m_flat());
      chk("wr_pulse", wr_pulse, m_pulse);
      chk("awready", awready, e_awready());
      chk("wready", wready, e_wready());
      chk("arready", arready, e_arready());
      chk("bvalid", bvalid, m_bvalid);
      chk("rvalid", rvalid, m_rvalid);
      if (m_bvalid) chk("bresp", bresp, m_bresp);
      if (m_rvalid) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", rresp, m_rresp);
      end
    end
  end

  // ---------------- stimulus ----------------
  // b_dly < 0 leaves the response un-acknowledged.
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly,
                          input int w_dly, input int b_dly,
                          output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, af, wf;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      awvalid = !aw_done && cyc >= aw_dly; awaddr = a;
      wvalid = !w_done && cyc >= w_dly; wdata = d; wstrb = s;
      af = awvalid && awready; wf = wvalid && wready;
      @(negedge ACLK); cyc++;
      if (af) aw_done = 1;
      if (wf) w_done = 1;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) chk("aw_w_timeout", 0, 1);
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      @(negedge ACLK); cyc++;
    end
    chk("b_latency", cyc, 1);
    resp = bresp;
    if (b_dly >= 0) begin
      repeat (b_dly) @(negedge ACLK);
      resp = bresp;
      bready = 1;
      @(negedge ACLK);
      bready = 0;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ar_dly,
                         input int r_dly, output logic [31:0] d,
                         output logic [1:0] resp);
    bit done = 0, f;
    int cyc = 0;
    while (!done && cyc < 100) begin
      arvalid = cyc >= ar_dly; araddr = a;
      f = arvalid && arready;
      @(negedge ACLK); cyc++;
      if (f) done = 1;
    end
    arvalid = 0;
    if (!done) chk("ar_timeout", 0, 1);
    cyc = 0;
    while (!rvalid && cyc < 20) begin
      @(negedge ACLK); cyc++;
    end
    chk("r_latency", cyc, 0);
    repeat (r_dly) @(negedge ACLK);
    d = rdata; resp = rresp;
    rready = 1;
    @(negedge ACLK);
    rready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r, r2;
    logic [31:0] d, d2;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_pulse", wr_pulse, 0);
    ARESET = 0;
    @(negedge ACLK);
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 4; i++) begin
      do_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, r);
      chk("wr_okay", r, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(6'(i * 4), 0, 0, d, r);
      chk("rd_data", d, 32'(i + 1));
      chk("rd_okay", r, 2'b00);
    end

    do_write(6'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0, r);
    chk("w_first_resp", r, 2'b00);
    do_write(6'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r);
    chk("same_cyc_resp", r, 2'b00);
    do_write(6'h10, 32'h00000044, 4'hF, 0, 2, 0, r);
    chk("aw_first_resp", r, 2'b00);
    do_read(6'h08, 0, 0, d, r);
    chk("reg2", d, 32'hDEADBEEF);

    do_write(6'h04, 32'h12345678, 4'h5, 0, 0, 0, r);
    do_read(6'h04, 0, 0, d, r);
    chk("strb_merge", d, 32'hFF34FF78);

    do_write(6'h20, 32'h99999999, 4'hF, 0, 0, 0, r);
    chk("oor_bresp", r, 2'b10);
    do_read(6'h3C, 0, 0, d, r);
    chk("oor_rdata", d, 0);
    chk("oor_rresp", r, 2'b10);

    do_write(6'h14, 32'h00000066, 4'h3, 0, 0, 5, r);
    chk("held_bresp", r, 2'b00);
    do_read(6'h0D, 0, 5, d, r);
    chk("held_rdata", d, 32'h4);

    fork
      do_write(6'h00, 32'h00000055, 4'hF, 0, 0, 0, r);
      do_read(6'h00, 1, 0, d2, r2);
    join
    chk("same_edge_old", d2, 32'h1);
    do_read(6'h00, 0, 0, d, r);
    chk("same_edge_new", d, 32'h55);

`ifdef REGBANK_STATUS_EN
    do_read(6'h1C, 0, 0, d, r);
    chk("status_rd", d, 32'hA5A5A5A5);
    do_write(6'h1C, 32'h12121212, 4'hF, 0, 0, 0, r);
    chk("status_wr_err", r, 2'b10);
    do_read(6'h1C, 0, 0, d, r);
    chk("status_kept", d, 32'hA5A5A5A5);
`else
    do_write(6'h1C, 32'h77777777, 4'hF, 0, 0, 0, r);
    chk("reg7_wr", r, 2'b00);
    do_read(6'h1C, 0, 0, d, r);
    chk("reg7_rd", d, 32'h77777777);
`endif

    do_write(6'h0C, 32'hCCCCCCCC, 4'hF, 0, 0, -1, r);
    chk("pre_rst_bvalid", bvalid, 1);
    ARESET = 1;
    @(negedge ACLK);
    chk("abort_bvalid", bvalid, 0);
    chk("abort_regs", regs_out[FW-DW-1:0], 0);
    ARESET = 0;
    @(negedge ACLK);
    do_write(6'h00, 32'hABCD0123, 4'hF, 0, 0, 0, r);
    do_read(6'h00, 0, 0, d, r);
    chk("after_abort", d, 32'hABCD0123);

    repeat (3) @(negedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
